// File: rtl/ffe_term_gen.sv
// Streaming FFE tap-product generator: sample history times per-tap coefficient, scaled and registered.
// Optional FFE_TERM_SAT_EN: saturate terms instead of wrapping, and add the sat_flag output.
module ffe_term_gen #(
    parameter int unsigned in_bits   = 8,
    parameter int unsigned coef_bits = 8,
    parameter int unsigned n_taps    = 3,
    parameter int unsigned out_bits  = 12,
    parameter int unsigned shift     = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [in_bits-1:0]           in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    input  logic                                coef_wr,
    input  logic [$clog2(n_taps)-1:0]           coef_addr,
    input  logic signed [coef_bits-1:0]         coef_data,
    output logic [n_taps-1:0][out_bits-1:0]     out_terms,
    output logic                                out_valid,
    input  logic                                out_ready
`ifdef FFE_TERM_SAT_EN
    ,
    output logic                                sat_flag
`endif
);

    localparam int unsigned aw = $clog2(n_taps);
    localparam int unsigned pw = in_bits + coef_bits;
    localparam logic [aw-1:0] cnt_max = aw'(n_taps - 1);

    logic signed [in_bits-1:0]   hist_q [n_taps];
    logic signed [in_bits-1:0]   hist_nxt [n_taps];
    logic signed [coef_bits-1:0] coef_q [n_taps];
    logic [aw-1:0]               cnt_q;
    logic [n_taps-1:0][out_bits-1:0] term_nxt;
    logic                        accept;
`ifdef FFE_TERM_SAT_EN
    logic [n_taps-1:0]           clip;
`endif

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Terms are formed from the history as it will look after this accept.
    always_comb begin
        logic signed [pw-1:0] a, b, prod, scl;
`ifdef FFE_TERM_SAT_EN
        logic [pw-out_bits:0] upper;
        clip = '0;
`endif
        term_nxt    = '0;
        hist_nxt[0] = in_data;
        for (int i = 1; i < int'(n_taps); i++) begin
            hist_nxt[i] = hist_q[i-1];
        end
        for (int i = 0; i < int'(n_taps); i++) begin
            a    = {{coef_bits{hist_nxt[i][in_bits-1]}}, hist_nxt[i]};
            b    = {{in_bits{coef_q[i][coef_bits-1]}}, coef_q[i]};
            prod = a * b;
            scl  = prod >>> shift;
`ifdef FFE_TERM_SAT_EN
            // Clamp whenever the dropped high bits are not a pure sign extension.
            upper = scl[pw-1:out_bits-1];
            if (!(&upper) && (|upper)) begin
                clip[i]     = 1'b1;
                term_nxt[i] = scl[pw-1] ? {1'b1, {(out_bits-1){1'b0}}}
                                        : {1'b0, {(out_bits-1){1'b1}}};
            end else begin
                term_nxt[i] = scl[out_bits-1:0];
            end
`else
            term_nxt[i] = scl[out_bits-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(n_taps); i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
            cnt_q     <= '0;
            out_terms <= '0;
            out_valid <= 1'b0;
`ifdef FFE_TERM_SAT_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            if (coef_wr && (32'(coef_addr) < n_taps)) begin
                coef_q[coef_addr] <= coef_data;
            end
            if (flush) begin
                for (int i = 0; i < int'(n_taps); i++) begin
                    hist_q[i] <= '0;
                end
                cnt_q     <= '0;
                out_terms <= '0;
                out_valid <= 1'b0;
`ifdef FFE_TERM_SAT_EN
                sat_flag  <= 1'b0;
`endif
            end else if (accept) begin
                for (int i = 0; i < int'(n_taps); i++) begin
                    hist_q[i] <= hist_nxt[i];
                end
                if (cnt_q != cnt_max) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                out_terms <= term_nxt;
                // Only a fully primed history yields a valid word.
                out_valid <= (cnt_q == cnt_max);
`ifdef FFE_TERM_SAT_EN
                sat_flag  <= |clip;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ffe_term_gen.sv
// Self-checking bench for ffe_term_gen: reference model plus scoreboard queue of expected words.
// Build with +define+FFE_TERM_SAT_EN to exercise the saturating variant.
module tb_ffe_term_gen;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              coef_wr;
    logic [1:0]        coef_addr;
    logic [7:0]        coef_data;
    logic [2:0][11:0]  out_terms;
    logic              out_valid;
    logic              out_ready;
`ifdef FFE_TERM_SAT_EN
    logic              sat_flag;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic signed [7:0] m_hist [3];
    logic signed [7:0] m_coef [3];
    int                m_cnt;
    logic              m_oval;
    logic [36:0]       m_last;
    logic [36:0]       sb [$];

    ffe_term_gen #(
        .in_bits  (8),
        .coef_bits(8),
        .n_taps   (3),
        .out_bits (12),
        .shift    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .coef_wr  (coef_wr),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_terms(out_terms),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef FFE_TERM_SAT_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] calc();
        logic [36:0] w;
        int          p, s;
        logic [31:0] sv;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            p  = int'(m_hist[i]) * int'(m_coef[i]);
            s  = p >>> 2;
            sv = s;
`ifdef FFE_TERM_SAT_EN
            if (s > 2047) begin
                w[i*12 +: 12] = 12'h7FF;
                w[36] = 1'b1;
            end else if (s < -2048) begin
                w[i*12 +: 12] = 12'h800;
                w[36] = 1'b1;
            end else begin
                w[i*12 +: 12] = sv[11:0];
            end
`else
            w[i*12 +: 12] = sv[11:0];
`endif
        end
        return w;
    endfunction

    function automatic logic [36:0] observed();
        logic sf;
`ifdef FFE_TERM_SAT_EN
        sf = sat_flag;
`else
        sf = 1'b0;
`endif
        return {sf, out_terms};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = '0;
            m_coef[i] = '0;
        end
        m_cnt  = 0;
        m_oval = 1'b0;
        m_last = '0;
        sb.delete();
    endtask

    // One clock: drive, check in_ready, advance model, clock, check outputs.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic        exp_rdy, acc;
        logic [36:0] w, got;
        in_valid = v;
        in_data  = d;
        #1;
        exp_rdy = !flush && (!m_oval || out_ready);
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
        end
        acc = v && exp_rdy;
        if (flush) begin
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
            m_cnt  = 0;
            m_oval = 1'b0;
            m_last = '0;
        end else if (acc) begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = d;
            w = calc();
            if (m_cnt == 2) sb.push_back(w);
            m_oval = (m_cnt == 2);
            if (m_cnt < 2) m_cnt++;
        end else if (out_ready) begin
            m_oval = 1'b0;
        end
        if (coef_wr && coef_addr < 2'd3) m_coef[coef_addr] = coef_data;
        @(posedge clk);
        #1;
        got = observed();
        n_cmp++;
        if (out_valid !== m_oval) begin
            n_err++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_oval);
        end
        if (flush) begin
            n_cmp++;
            if (got !== 37'd0) begin
                n_err++;
                $display("FAIL flush_clear: got %h want 0", got);
            end
        end else if (acc && m_oval) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty: got %h want queued word", got);
            end else begin
                w = sb.pop_front();
                m_last = w;
                if (got !== w) begin
                    n_err++;
                    $display("FAIL word: got %h want %h", got, w);
                end
            end
        end else if (m_oval) begin
            n_cmp++;
            if (got !== m_last) begin
                n_err++;
                $display("FAIL held_word: got %h want %h", got, m_last);
            end
        end
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wr_coef(input logic [1:0] a, input logic [7:0] c);
        coef_wr   = 1'b1;
        coef_addr = a;
        coef_data = c;
        cycle(1'b0, 8'd0);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || out_terms !== 36'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got v=%b t=%h r=%b want 0 0 1", out_valid, out_terms, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        wr_coef(2'd0, 8'd5);
        cycle(1'b1, 8'd1);
        cycle(1'b1, 8'd2);
        cycle(1'b1, 8'd3);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_terms !== 36'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midstream_reset: got v=%b t=%h r=%b want 0 0 1",
                     out_valid, out_terms, in_ready);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 8'd7);
        cycle(1'b1, 8'd8);
        cycle(1'b1, 8'd9);
    endtask

    task automatic test_basic();
        logic [35:0] e;
        flush = 1'b1;
        cycle(1'b0, 8'd0);
        wr_coef(2'd0, 8'd4);
        wr_coef(2'd1, 8'hF8);
        wr_coef(2'd2, 8'd16);
        cycle(1'b1, 8'd10);
        cycle(1'b1, 8'd20);
        cycle(1'b1, 8'd30);
        e = {12'd40, 12'hFD8, 12'd30};
        n_cmp++;
        if (out_valid !== 1'b1 || out_terms !== e) begin
            n_err++;
            $display("FAIL basic_terms: got v=%b %h want 1 %h", out_valid, out_terms, e);
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] e;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'd40);
        out_ready = 1'b1;
        cycle(1'b1, 8'd40);
        e = {12'h050, 12'hFC4, 12'h028};
        n_cmp++;
        if (out_terms !== e) begin
            n_err++;
            $display("FAIL release_word: got %h want %h", out_terms, e);
        end
    endtask

    task automatic test_sat();
        logic [11:0] e;
        wr_coef(2'd0, 8'd127);
        cycle(1'b1, 8'd127);
`ifdef FFE_TERM_SAT_EN
        e = 12'h7FF;
        n_cmp++;
        if (sat_flag !== 1'b1) begin
            n_err++;
            $display("FAIL sat_flag: got %b want 1", sat_flag);
        end
`else
        e = 12'hFC0;
`endif
        n_cmp++;
        if (out_terms[0] !== e) begin
            n_err++;
            $display("FAIL term0_fit: got %h want %h", out_terms[0], e);
        end
    endtask

    task automatic test_coef_concurrent();
        coef_wr   = 1'b1;
        coef_addr = 2'd1;
        coef_data = 8'd2;
        cycle(1'b1, 8'd5);
        cycle(1'b1, 8'd6);
        n_cmp++;
        if (out_terms[1] !== 12'h002) begin
            n_err++;
            $display("FAIL new_coef_term1: got %h want 002", out_terms[1]);
        end
        wr_coef(2'd3, 8'd99);
        cycle(1'b1, 8'd7);
    endtask

    task automatic test_flush();
        flush = 1'b1;
        cycle(1'b1, 8'd50);
        cycle(1'b1, 8'd1);
        cycle(1'b1, 8'd2);
        cycle(1'b1, 8'd3);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reprime_valid: got %b want 1", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            coef_wr   = ($urandom_range(0, 7) == 0);
            coef_addr = 2'($urandom_range(0, 3));
            coef_data = 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
        end
        out_ready = 1'b1;
        cycle(1'b0, 8'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b1;
        model_reset();
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_sat();
        test_coef_concurrent();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
